lpf_sched: RTL

Time-multiplexed scheduler that shares one first-order low-pass datapath (y ← (3·y + x)/4) among NCH input channels such as phase currents, bus voltage and servo feedback. It generates the sample tick internally and sweeps the channels in a fixed order on each tick. For each channel it performs a valid/ready input handshake, reads that channel's stored filter state, computes the update and writes it back. Each filtered result is presented on a shared output with a channel tag. It sits between the ADC front-end registers and the control loops.

---
 rtl/lpf_pkg.sv | 18 +
 rtl/lpf_step.sv | 29 ++
 rtl/lpf_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lpf_pkg.sv
// Shared types and helpers for the time-multiplexed low-pass filter scheduler.
package lpf_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        WRITE
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpf_step.sv
// One first-order low-pass update: y_next = floor((3*y + x) / 4).
// The result lies between y and x, so truncation back to WIDTH never wraps.
module lpf_step
    import lpf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y_next
);

    logic signed [WIDTH+1:0] ye;
    logic signed [WIDTH+1:0] xe;
    logic signed [WIDTH+1:0] sum;
    logic [1:0]              unused_frac;

    // Sign-extend both operands by two bits so 3*y + x cannot overflow.
    always_comb begin
        ye  = {{2{y[WIDTH-1]}}, y};
        xe  = {{2{x[WIDTH-1]}}, x};
        sum = (ye <<< 1) + ye + xe;
    end

    // Dropping the two low bits of a two's-complement value is floor division by 4.
    assign y_next      = sum[WIDTH+1:2];
    assign unused_frac = sum[1:0];

endmodule

// File: rtl/lpf_sched.sv
// Sweeps NCH channels through one shared low-pass datapath on every sample tick.
// Each channel gets a fixed LOAD/CALC/WRITE slot whether or not it had a sample.
module lpf_sched
    import lpf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = 4,
    parameter int DIV   = 100,
    parameter int CHW   = idx_w(NCH)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 clr_ovr,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CHW-1:0]       out_ch,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int              CNTW    = idx_w(DIV);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DIV - 1);
    localparam logic [CHW-1:0]  CH_LAST = CHW'(NCH - 1);

    logic [CNTW-1:0]  cnt;
    logic             tick;
    state_t           state;
    logic [CHW-1:0]   ch;
    logic             acc;
    logic [WIDTH-1:0] x_lat;
    logic [WIDTH-1:0] st [NCH];
    logic [WIDTH-1:0] in_arr [NCH];
    logic [WIDTH-1:0] y_cur;
    logic [WIDTH-1:0] y_next;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign in_arr[k] = in_data[k*WIDTH +: WIDTH];
    end

    assign tick  = en && (cnt == CNT_MAX);
    assign y_cur = st[ch];

    lpf_step #(.WIDTH(WIDTH)) u_step (
        .y      (y_cur),
        .x      (x_lat),
        .y_next (y_next)
    );

    // Sample-tick divider: free-runs 0..DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                         cnt <= '0;
        else if (!en || cnt == CNT_MAX)    cnt <= '0;
        else                               cnt <= cnt + CNTW'(1);
    end

    // Sweep FSM with its registered outputs and the per-channel filter state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            ch        <= '0;
            acc       <= 1'b0;
            x_lat     <= '0;
            in_ready  <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < NCH; k++) st[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= LOAD;
                        ch       <= '0;
                        busy     <= 1'b1;
                        in_ready <= NCH'(1);
                    end
                end
                LOAD: begin
                    // in_valid is only looked at here; a missing sample skips the channel.
                    acc      <= in_valid[ch];
                    x_lat    <= in_arr[ch];
                    in_ready <= '0;
                    state    <= CALC;
                end
                CALC: begin
                    if (acc) begin
                        out_data <= y_next;
                        out_ch   <= ch;
                        st[ch]   <= y_next;
                    end
                    out_valid <= acc;
                    state     <= WRITE;
                end
                WRITE: begin
                    out_valid <= 1'b0;
                    if (ch == CH_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ch       <= ch + CHW'(1);
                        in_ready <= NCH'(1) << (ch + CHW'(1));
                        state    <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a tick that lands mid-sweep is dropped and flagged; set beats clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                overrun <= 1'b0;
        else if (tick && busy)    overrun <= 1'b1;
        else if (clr_ovr)         overrun <= 1'b0;
    end

endmodule
